// File: rtl/eth_tx_framer_if.sv
// rtl/eth_tx_framer_if.sv - payload dibit stream (valid/ready/last) into the Ethernet TX framer
interface eth_tx_framer_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiil;
    logic       axiir;

    modport master (output axiiv, output axiid, output axiil, input axiir);
    modport slave  (input axiiv, input axiid, input axiil, output axiir);
endinterface

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - RMII Ethernet II transmit framer; optional 802.1Q tag via ETH_TX_VLAN_EN
module eth_tx_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h69695A065491,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
`ifdef ETH_TX_VLAN_EN
    parameter logic [15:0] VLAN_TCI    = 16'h0001,
`endif
    parameter int          IFG_DIBITS  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    eth_tx_framer_if.slave    s_axi,
    output logic              phy_txen,
    output logic [1:0]        phy_txd,
    output logic              busy,
    output logic              frame_done,
    output logic              err_underrun,
    output logic              err_oversize
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC,
`ifdef ETH_TX_VLAN_EN
        S_VLAN,
`endif
        S_TYPE, S_DATA, S_PAD, S_FCS, S_DRAIN, S_IFG
    } state_t;

`ifdef ETH_TX_VLAN_EN
    // The 4-byte tag counts towards the 64-byte minimum frame, so less padding is needed
    localparam int          PAD_BYTES  = MIN_PAYLOAD - 4;
    localparam logic [47:0] VLAN_FIELD = {16'h8100, VLAN_TCI, 16'h0000};
`else
    localparam int          PAD_BYTES  = MIN_PAYLOAD;
`endif
    localparam logic [12:0] MIN_DIBITS = 13'(PAD_BYTES * 4);
    localparam logic [12:0] MAX_DIBITS = 13'(MAX_PAYLOAD * 4);
    localparam logic [15:0] IFG_LAST   = 16'(IFG_DIBITS - 1);
    localparam logic [47:0] TYPE_FIELD = {ETHERTYPE, 32'h0000_0000};

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [12:0] pay_q, pay_d;
    logic [31:0] crc_q, crc_d;
    logic        under_q, under_d;
    logic        over_q, over_d;
    logic        crc_en;
    logic        ready;
    logic [12:0] pay_inc;
    logic [15:0] cnt_sat;
    logic [31:0] crc_res;
    logic [31:0] fcs_word;
    logic [31:0] fcs_tx;

    // Reflected CRC-32 advanced by one dibit, bit 0 first (wire order)
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 2; b++) begin
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Dibit idx of a left-aligned field: bytes MSB first, each byte LSB dibit first
    function automatic logic [1:0] field_dibit(input logic [47:0] f, input logic [4:0] idx);
        logic [5:0] pos;
        pos = 6'd40 - {idx[4:2], 3'b000} + {3'b000, idx[1:0], 1'b0};
        return f[pos +: 2];
    endfunction

    assign pay_inc  = pay_q + 13'd1;
    assign cnt_sat  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // Byte-swapped so the first transmitted FCS byte sits in [31:24]
    assign crc_res  = ~crc_q;
    assign fcs_word = {crc_res[7:0], crc_res[15:8], crc_res[23:16], crc_res[31:24]};
    assign fcs_tx   = (under_q || over_q) ? ~fcs_word : fcs_word;
    assign busy     = (state_q != S_IDLE);
    assign s_axi.axiir = ready;

    // State, counters, running CRC and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            crc_q   <= '1;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            crc_q   <= crc_d;
            under_q <= under_d;
            over_q  <= over_d;
        end
    end

    // Frame sequencing, PHY pin drive and CRC feed
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        pay_d        = pay_q;
        crc_d        = crc_q;
        under_d      = under_q;
        over_d       = over_q;
        crc_en       = 1'b0;
        ready        = 1'b0;
        phy_txen     = 1'b0;
        phy_txd      = 2'b00;
        frame_done   = 1'b0;
        err_underrun = 1'b0;
        err_oversize = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                pay_d   = '0;
                crc_d   = '1;
                under_d = 1'b0;
                over_d  = 1'b0;
                if (s_axi.axiiv) state_d = S_PRE;
            end
            S_PRE: begin
                phy_txen = 1'b1;
                phy_txd  = 2'b01;
                if (cnt_q == 16'd27) begin state_d = S_SFD; cnt_d = '0; end
            end
            S_SFD: begin
                phy_txen = 1'b1;
                phy_txd  = (cnt_q[1:0] == 2'd3) ? 2'b11 : 2'b01;
                if (cnt_q == 16'd3) begin state_d = S_DST; cnt_d = '0; end
            end
            S_DST: begin
                phy_txen = 1'b1;
                crc_en   = 1'b1;
                phy_txd  = field_dibit(DST_MAC, cnt_q[4:0]);
                if (cnt_q == 16'd23) begin state_d = S_SRC; cnt_d = '0; end
            end
            S_SRC: begin
                phy_txen = 1'b1;
                crc_en   = 1'b1;
                phy_txd  = field_dibit(SRC_MAC, cnt_q[4:0]);
                if (cnt_q == 16'd23) begin
`ifdef ETH_TX_VLAN_EN
                    state_d = S_VLAN;
`else
                    state_d = S_TYPE;
`endif
                    cnt_d = '0;
                end
            end
`ifdef ETH_TX_VLAN_EN
            S_VLAN: begin
                phy_txen = 1'b1;
                crc_en   = 1'b1;
                phy_txd  = field_dibit(VLAN_FIELD, cnt_q[4:0]);
                if (cnt_q == 16'd15) begin state_d = S_TYPE; cnt_d = '0; end
            end
`endif
            S_TYPE: begin
                phy_txen = 1'b1;
                crc_en   = 1'b1;
                phy_txd  = field_dibit(TYPE_FIELD, cnt_q[4:0]);
                if (cnt_q == 16'd7) begin state_d = S_DATA; cnt_d = '0; end
            end
            S_DATA: begin
                phy_txen = 1'b1;
                crc_en   = 1'b1;
                ready    = 1'b1;
                pay_d    = pay_inc;
                cnt_d    = '0;
                if (!s_axi.axiiv) begin
                    // Source starved us: a 00 dibit goes out and the frame is closed as bad
                    under_d = 1'b1;
                    state_d = (pay_inc < MIN_DIBITS) ? S_PAD : S_FCS;
                end else begin
                    phy_txd = s_axi.axiid;
                    if (s_axi.axiil) begin
                        state_d = (pay_inc < MIN_DIBITS) ? S_PAD : S_FCS;
                    end else if (pay_inc == MAX_DIBITS) begin
                        over_d  = 1'b1;
                        state_d = S_FCS;
                    end
                end
            end
            S_PAD: begin
                phy_txen = 1'b1;
                crc_en   = 1'b1;
                pay_d    = pay_inc;
                if (pay_inc == MIN_DIBITS) begin state_d = S_FCS; cnt_d = '0; end
            end
            S_FCS: begin
                phy_txen = 1'b1;
                phy_txd  = field_dibit({fcs_tx, 16'h0000}, cnt_q[4:0]);
                if (cnt_q == 16'd15) begin
                    frame_done   = 1'b1;
                    err_underrun = under_q;
                    err_oversize = over_q;
                    state_d      = over_q ? S_DRAIN : S_IFG;
                    cnt_d        = '0;
                end
            end
            S_DRAIN: begin
                // Swallow the rest of the oversized payload while the gap already elapses
                ready = 1'b1;
                cnt_d = cnt_sat;
                if (s_axi.axiiv && s_axi.axiil) state_d = S_IFG;
            end
            S_IFG: begin
                cnt_d = cnt_sat;
                if (cnt_q >= IFG_LAST) begin
                    cnt_d   = '0;
                    pay_d   = '0;
                    crc_d   = '1;
                    under_d = 1'b0;
                    over_d  = 1'b0;
                    state_d = s_axi.axiiv ? S_PRE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (crc_en) crc_d = crc_dibit(crc_q, phy_txd);
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - scoreboard testbench for eth_tx_framer
module tb_eth_tx_framer;
    localparam int MAXB = 64;
`ifdef ETH_TX_VLAN_EN
    localparam int MINB = 42;
`else
    localparam int MINB = 46;
`endif

    typedef struct {
        int   len;
        logic under;
        logic over;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       phy_txen;
    logic [1:0] phy_txd;
    logic       busy;
    logic       frame_done;
    logic       err_underrun;
    logic       err_oversize;

    always #10 clk = ~clk;

    eth_tx_framer_if bus();

    eth_tx_framer #(.MAX_PAYLOAD(MAXB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi        (bus),
        .phy_txen     (phy_txen),
        .phy_txd      (phy_txd),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_underrun (err_underrun),
        .err_oversize (err_oversize)
    );

    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    frame_t     frm_q[$];
    int         gap_q[$];
    logic [7:0] body[$];
    bit         mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pbyte(input int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    function automatic logic [31:0] crc_body();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (body[k]) begin
            c = c ^ {24'h0, body[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] v);
        for (int j = 0; j < 4; j++) exp_q.push_back(v[2*j +: 2]);
    endtask

    // Expected wire image of one frame: preamble, SFD, header, payload+pad, FCS
    task automatic push_frame(input int npat, input bit under, input bit over);
        logic [31:0] c;
        logic [31:0] fcs;
        frame_t      f;
        body.delete();
        repeat (6) body.push_back(8'hFF);
        body.push_back(8'h69); body.push_back(8'h69); body.push_back(8'h5A);
        body.push_back(8'h06); body.push_back(8'h54); body.push_back(8'h91);
`ifdef ETH_TX_VLAN_EN
        body.push_back(8'h81); body.push_back(8'h00); body.push_back(8'h00); body.push_back(8'h01);
`endif
        body.push_back(8'h88); body.push_back(8'hB5);
        for (int k = 0; k < npat; k++) body.push_back(pbyte(k));
        for (int k = npat; k < MINB; k++) body.push_back(8'h00);
        repeat (28) exp_q.push_back(2'b01);
        repeat (3) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        foreach (body[k]) push_byte(body[k]);
        c   = crc_body();
        fcs = (under || over) ? c : ~c;
        push_byte(fcs[7:0]);
        push_byte(fcs[15:8]);
        push_byte(fcs[23:16]);
        push_byte(fcs[31:24]);
        f.len   = 32 + 4 * body.size() + 16;
        f.under = under;
        f.over  = over;
        frm_q.push_back(f);
    endtask

    // Payload source: n dibits with last on n-1; gap_at drops valid once and abandons the rest
    task automatic drive(input int n, input int gap_at, input bit keep);
        int         i;
        int         cyc;
        logic [7:0] b;
        logic       hs;
        i   = 0;
        cyc = 0;
        while (i < n && cyc < 4000) begin
            if (i == gap_at) begin
                bus.axiiv = 1'b0;
                bus.axiil = 1'b0;
                @(posedge clk); #1;
                break;
            end
            b = pbyte(i / 4);
            bus.axiiv = 1'b1;
            bus.axiid = b[2*(i%4) +: 2];
            bus.axiil = (i == n - 1);
            @(negedge clk);
            hs = bus.axiir;
            @(posedge clk); #1;
            if (hs) i++;
            cyc++;
        end
        check("drive_complete", ((i == n) || (i == gap_at)) ? 1 : 0, 1);
        if (!keep) begin
            bus.axiiv = 1'b0;
            bus.axiil = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_reached", busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        check("frames_empty", frm_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pop expected dibits while txen is high; close frames on frame_done
    int     txcnt = 0;
    int     lowcnt = 0;
    logic   prev_txen = 1'b0;
    frame_t mon_f;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            txcnt  = 0;
            lowcnt = 0;
            prev_txen = 1'b0;
        end else begin
            if (phy_txen) begin
                if (!prev_txen && gap_q.size() > 0) check("ifg_gap", lowcnt, gap_q.pop_front());
                txcnt++;
                lowcnt = 0;
                check("exp_available", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) check($sformatf("txd[%0d]", txcnt - 1), phy_txd, exp_q.pop_front());
                if (frame_done) begin
                    check("frame_pending", (frm_q.size() > 0) ? 1 : 0, 1);
                    if (frm_q.size() > 0) begin
                        mon_f = frm_q.pop_front();
                        check("frame_len", txcnt, mon_f.len);
                        check("err_underrun", err_underrun, mon_f.under);
                        check("err_oversize", err_oversize, mon_f.over);
                    end
                    txcnt = 0;
                end else begin
                    check("err_without_done", {err_underrun, err_oversize}, 0);
                end
            end else begin
                lowcnt++;
                check("status_while_txen_low", {frame_done, err_underrun, err_oversize}, 0);
            end
            prev_txen = phy_txen;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int hs_n;
        int cyc;
        logic hs;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        bus.axiil = 1'b0;
        #15;
        check("rst_txen", phy_txen, 0);
        check("rst_txd", phy_txd, 0);
        check("rst_axiir", bus.axiir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_errs", {err_underrun, err_oversize}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // minimum-size payload, no padding
        push_frame(46, 1'b0, 1'b0);
        drive(184, -1, 1'b0);
        wait_idle();

        // short payload padded with zeros
        push_frame(10, 1'b0, 1'b0);
        drive(40, -1, 1'b0);
        wait_idle();

        // underrun at payload dibit 100
        push_frame(25, 1'b1, 1'b0);
        drive(200, 100, 1'b0);
        wait_idle();

        // oversize: 80 bytes against a 64-byte limit, tail drained
        push_frame(MAXB, 1'b0, 1'b1);
        drive(320, -1, 1'b0);
        wait_idle();

        // back-to-back frames with valid held through the gap
        push_frame(46, 1'b0, 1'b0);
        push_frame(46, 1'b0, 1'b0);
        drive(184, -1, 1'b1);
        gap_q.push_back(48);
        drive(184, -1, 1'b0);
        wait_idle();

        // reset in the middle of the payload
        mon_en = 1'b0;
        hs_n = 0;
        cyc  = 0;
        while (hs_n < 50 && cyc < 400) begin
            bus.axiiv = 1'b1;
            bus.axiid = 2'(hs_n);
            @(negedge clk);
            hs = bus.axiir;
            @(posedge clk); #1;
            if (hs) hs_n++;
            cyc++;
        end
        #3;
        check("txen_before_reset", phy_txen, 1);
        rst_n = 1'b0;
        #1;
        check("reset_txen", phy_txen, 0);
        check("reset_busy", busy, 0);
        check("reset_axiir", bus.axiir, 0);
        bus.axiiv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // clean frame after reset: CRC must start fresh
        push_frame(46, 1'b0, 1'b0);
        drive(184, -1, 1'b0);
        wait_idle();

`ifdef ETH_TX_VLAN_EN
        // tagged frame, 42-byte payload needs no padding
        push_frame(42, 1'b0, 1'b0);
        drive(168, -1, 1'b0);
        wait_idle();
`endif

        check("gap_queue_empty", gap_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
